sa_load_sequencer: RTL and testbench

//  Sequences one matrix job on the cascaded systolic array: weight preload, skewed activation streaming, result capture.
//  - Phase 1: reads ROW weight words from the weight buffer while holding the array's in_sel high.
//  - Phase 2: reads the activation vectors from the activation buffer with in_sel low and drives the per-row valid bits of in_west with a diagonal skew.
//  - Phase 3: counts result-valid pulses and writes results to the result buffer.
//  - Sits between the host/command logic and systolic_top together with its three buffer RAMs.

---
 rtl/sa_pkg.sv | 27 ++
 rtl/sa_load_sequencer_if.sv | 61 ++++++
 rtl/sa_skew_line.sv | 38 +++
 rtl/sa_load_sequencer.sv | 179 +++++++++++++++++
 tb/tb_sa_load_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array load sequencer: FSM state codes,
// buffer read latency and a width helper.
package sa_pkg;

    // Cycles from a buffer read strobe to its data word on the read port.
    localparam int SA_RD_LAT = 1;

    typedef logic [2:0] sa_state_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOADW  = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sa_load_sequencer_if.sv
// Command, buffer-port and array-control bundle of the load sequencer.
// The host/array side takes the master modport; the sequencer takes slave.
interface sa_load_sequencer_if #(
    parameter int ROW    = 9,
    parameter int W_ADDR = 8,
    parameter int W_CNT  = 9
);

    logic              in_start;
    logic              in_abort;
    logic [W_CNT-1:0]  in_num_vec;
    logic              out_busy;
    logic              out_done;
    logic              out_err;
    logic              out_w_rd_en;
    logic [W_ADDR-1:0] out_w_rd_addr;
    logic              out_d_rd_en;
    logic [W_ADDR-1:0] out_d_rd_addr;
    logic              out_sa_sel;
    logic [ROW-1:0]    out_row_valid;
    logic              in_res_valid;
    logic              out_res_wr_en;
    logic [W_ADDR-1:0] out_res_wr_addr;

    modport master (
        output in_start,
        output in_abort,
        output in_num_vec,
        output in_res_valid,
        input  out_busy,
        input  out_done,
        input  out_err,
        input  out_w_rd_en,
        input  out_w_rd_addr,
        input  out_d_rd_en,
        input  out_d_rd_addr,
        input  out_sa_sel,
        input  out_row_valid,
        input  out_res_wr_en,
        input  out_res_wr_addr
    );

    modport slave (
        input  in_start,
        input  in_abort,
        input  in_num_vec,
        input  in_res_valid,
        output out_busy,
        output out_done,
        output out_err,
        output out_w_rd_en,
        output out_w_rd_addr,
        output out_d_rd_en,
        output out_d_rd_addr,
        output out_sa_sel,
        output out_row_valid,
        output out_res_wr_en,
        output out_res_wr_addr
    );

endinterface

// File: rtl/sa_skew_line.sv
// Diagonal skew for the per-row valid bits: q[0] is the registered input,
// q[r] is q[0] delayed by r further cycles.
module sa_skew_line #(
    parameter int ROW = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           din,
    output logic [ROW-1:0] q
);

    logic [ROW-1:0] stage_reg;
    logic [ROW-1:0] stage_next;

    generate
        for (genvar gi = 0; gi < ROW; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = din;
            end else begin : g_tail
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else if (clr) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q = stage_reg;

endmodule

// File: rtl/sa_load_sequencer.sv
// Sequences one systolic-array job: weight preload, skewed activation
// streaming, and result capture into the result buffer.
module sa_load_sequencer
    import sa_pkg::*;
#(
    parameter int ROW    = 9,
    parameter int COL    = 64,
    parameter int W_ADDR = 8,
    parameter int W_CNT  = 9
) (
    input  logic               in_clk,
    input  logic               in_rst,
    sa_load_sequencer_if.slave bus
);

    // LOADW lingers until the final weight word has arrived from the buffer.
    localparam int W_END  = ROW + SA_RD_LAT - 1;
    localparam int W_WCNT = clog2(W_END + 1);

    localparam logic [W_CNT-1:0]  MAX_N  = W_CNT'(2 ** W_ADDR);
    localparam logic [W_WCNT-1:0] W_LAST = W_WCNT'(W_END);
    localparam logic [W_WCNT-1:0] W_ROWS = W_WCNT'(ROW);

    generate
        if (W_CNT < W_ADDR + 1) begin : g_bad_cnt
            $error("W_CNT must be at least W_ADDR+1");
        end
        if (((COL * 32) % 32) != 0) begin : g_bad_col
            $error("COL*32 must be a multiple of 32");
        end
    endgenerate

    sa_state_t         state_reg, state_next;
    logic [W_CNT-1:0]  n_reg, n_next;
    logic [W_WCNT-1:0] w_cnt_reg, w_cnt_next;
    logic [W_CNT-1:0]  d_cnt_reg, d_cnt_next;
    logic [W_CNT-1:0]  res_cnt_reg, res_cnt_next;
    logic              err_reg, err_next;
    logic              bad_done_reg, bad_done_next;
    logic              sa_sel_reg, sa_sel_next;

    logic              w_rd_en;
    logic              d_rd_en;
    logic              res_seen;
    logic              res_wr;
    logic              res_over;
    logic              num_bad;
    logic [ROW-1:0]    row_valid;

    // Counters are W_CNT wide so N = 2^W_ADDR compares without wrapping.
    assign w_rd_en  = (state_reg == S_LOADW) && (w_cnt_reg < W_ROWS);
    assign d_rd_en  = (state_reg == S_STREAM) && (d_cnt_reg < n_reg);
    assign res_seen = bus.in_res_valid && (state_reg != S_IDLE);
    assign res_wr   = res_seen && (res_cnt_reg < n_reg);
    assign res_over = res_seen && !(res_cnt_reg < n_reg);
    assign num_bad  = (bus.in_num_vec == '0) || (bus.in_num_vec > MAX_N);

    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        w_cnt_next    = w_cnt_reg;
        d_cnt_next    = d_cnt_reg;
        res_cnt_next  = res_cnt_reg;
        err_next      = err_reg;
        bad_done_next = 1'b0;
        sa_sel_next   = w_rd_en;

        if (d_rd_en) begin
            d_cnt_next = d_cnt_reg + 1'b1;
        end
        if (res_wr) begin
            res_cnt_next = res_cnt_reg + 1'b1;
        end
        if (res_over) begin
            err_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (bus.in_start) begin
                    n_next       = bus.in_num_vec;
                    w_cnt_next   = '0;
                    d_cnt_next   = '0;
                    res_cnt_next = '0;
                    if (num_bad) begin
                        err_next      = 1'b1;
                        bad_done_next = 1'b1;
                    end else begin
                        err_next   = 1'b0;
                        state_next = S_LOADW;
                    end
                end
            end
            S_LOADW: begin
                if (w_cnt_reg == W_LAST) begin
                    state_next = S_GAP;
                end else begin
                    w_cnt_next = w_cnt_reg + 1'b1;
                end
            end
            S_GAP: begin
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (d_rd_en && (d_cnt_reg == n_reg - 1'b1)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_cnt_reg == n_reg) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start, and
        // leaves the error flag exactly as it was.
        if (bus.in_abort) begin
            state_next    = S_IDLE;
            w_cnt_next    = '0;
            d_cnt_next    = '0;
            res_cnt_next  = '0;
            err_next      = err_reg;
            bad_done_next = 1'b0;
            sa_sel_next   = 1'b0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            w_cnt_reg    <= '0;
            d_cnt_reg    <= '0;
            res_cnt_reg  <= '0;
            err_reg      <= 1'b0;
            bad_done_reg <= 1'b0;
            sa_sel_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            w_cnt_reg    <= w_cnt_next;
            d_cnt_reg    <= d_cnt_next;
            res_cnt_reg  <= res_cnt_next;
            err_reg      <= err_next;
            bad_done_reg <= bad_done_next;
            sa_sel_reg   <= sa_sel_next;
        end
    end

    sa_skew_line #(
        .ROW (ROW)
    ) u_skew (
        .clk (in_clk),
        .rst (in_rst),
        .clr (bus.in_abort),
        .din (d_rd_en),
        .q   (row_valid)
    );

    assign bus.out_busy        = (state_reg != S_IDLE);
    assign bus.out_done        = (state_reg == S_DONE) || bad_done_reg;
    assign bus.out_err         = err_reg;
    assign bus.out_w_rd_en     = w_rd_en;
    assign bus.out_w_rd_addr   = w_rd_en ? W_ADDR'(w_cnt_reg) : '0;
    assign bus.out_d_rd_en     = d_rd_en;
    assign bus.out_d_rd_addr   = d_rd_en ? d_cnt_reg[W_ADDR-1:0] : '0;
    assign bus.out_sa_sel      = sa_sel_reg;
    assign bus.out_row_valid   = row_valid;
    assign bus.out_res_wr_en   = res_wr;
    assign bus.out_res_wr_addr = res_wr ? res_cnt_reg[W_ADDR-1:0] : '0;

endmodule

// File: tb/tb_sa_load_sequencer.sv
// Self-checking bench: per-cycle comparison of every sequencer output against
// a cycle-timeline model derived from job length and result latency.
module tb_sa_load_sequencer;

    localparam int ROW    = 9;
    localparam int COL    = 64;
    localparam int W_ADDR = 8;
    localparam int W_CNT  = 9;
    // First activation read cycle, counting the start cycle as 0.
    localparam int D0     = ROW + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_err = 0;

    sa_load_sequencer_if #(.ROW(ROW), .W_ADDR(W_ADDR), .W_CNT(W_CNT)) bus ();

    sa_load_sequencer #(
        .ROW    (ROW),
        .COL    (COL),
        .W_ADDR (W_ADDR),
        .W_CNT  (W_CNT)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {24'd0, bus.out_busy, bus.out_done, bus.out_err,
                bus.out_w_rd_en, bus.out_w_rd_addr, bus.out_d_rd_en, bus.out_d_rd_addr,
                bus.out_sa_sel, bus.out_row_valid, bus.out_res_wr_en, bus.out_res_wr_addr};
    endfunction

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            bus.in_res_valid = 1'($urandom_range(1));
            @(negedge clk);
            check_val("idle_wr", {bus.out_res_wr_en, bus.out_res_wr_addr}, '0);
            check_val("idle_busy", bus.out_busy, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.in_res_valid = 1'b0;
    endtask

    // Runs one job starting now; results arrive lat cycles after each row-0
    // valid. abort_at >= 0 raises abort together with start at that cycle.
    task automatic run_job(input int n, input int lat, input bit ovr, input int abort_at);
        int p0, lw, c_done, c_last, err_prev, k;
        bit gone;
        logic [W_ADDR:0] exp_w, exp_d, exp_wr;
        logic [ROW-1:0]  exp_rv;
        logic            exp_busy, exp_done, exp_sel, exp_err;

        p0       = D0 + 1 + lat;
        lw       = p0 + n - 1;
        c_done   = ((D0 + n > lw + 1) ? D0 + n : lw + 1) + 1;
        c_last   = (abort_at >= 0) ? abort_at + 3 : c_done + 1;
        err_prev = model_err;

        bus.in_start   = 1'b1;
        bus.in_num_vec = W_CNT'(n);
        for (int c = 0; c <= c_last; c++) begin
            gone = (abort_at >= 0) && (c > abort_at);
            k    = c - p0;
            if (c > 0) begin
                if (abort_at >= 0) begin
                    bus.in_start = (c == abort_at);
                end else begin
                    bus.in_start = (c >= 2) && (c <= c_done) && ($urandom_range(7) == 0);
                end
                if (bus.in_start) begin
                    bus.in_num_vec = W_CNT'($urandom_range(1, 300));
                end
            end
            bus.in_abort     = (c == abort_at);
            bus.in_res_valid = !gone && ((k >= 0 && k < n) || (ovr && k == n));

            @(negedge clk);
            exp_busy = !gone && (c >= 1) && (c <= c_done);
            exp_done = !gone && (c == c_done);
            exp_sel  = !gone && (c >= 2) && (c <= ROW + 1);
            exp_w    = (!gone && c >= 1 && c <= ROW) ? {1'b1, W_ADDR'(c - 1)} : '0;
            exp_d    = (!gone && c >= D0 && c < D0 + n) ? {1'b1, W_ADDR'(c - D0)} : '0;
            exp_wr   = (!gone && k >= 0 && k < n) ? {1'b1, W_ADDR'(k)} : '0;
            exp_err  = (c == 0) ? (err_prev != 0) : (ovr && c > p0 + n);
            exp_rv   = '0;
            for (int r = 0; r < ROW; r++) begin
                exp_rv[r] = !gone && (c >= D0 + 1 + r) && (c <= D0 + n + r);
            end
            check_val($sformatf("c%0d busy", c), bus.out_busy, exp_busy);
            check_val($sformatf("c%0d done", c), bus.out_done, exp_done);
            check_val($sformatf("c%0d err", c), bus.out_err, exp_err);
            check_val($sformatf("c%0d sa_sel", c), bus.out_sa_sel, exp_sel);
            check_val($sformatf("c%0d w_rd", c), {bus.out_w_rd_en, bus.out_w_rd_addr}, exp_w);
            check_val($sformatf("c%0d d_rd", c), {bus.out_d_rd_en, bus.out_d_rd_addr}, exp_d);
            check_val($sformatf("c%0d row_valid", c), bus.out_row_valid, exp_rv);
            check_val($sformatf("c%0d res_wr", c), {bus.out_res_wr_en, bus.out_res_wr_addr}, exp_wr);
            @(posedge clk);
            #1;
        end
        bus.in_start     = 1'b0;
        bus.in_abort     = 1'b0;
        bus.in_res_valid = 1'b0;
        model_err        = ovr ? 1 : 0;
        $display("job n=%0d lat=%0d overrun=%0d abort_at=%0d done_cycle=%0d checks=%0d",
                 n, lat, ovr, abort_at, (abort_at >= 0) ? -1 : c_done, n_checks);
    endtask

    task automatic bad_job(input int n);
        bus.in_start   = 1'b1;
        bus.in_num_vec = W_CNT'(n);
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) begin
                bus.in_start = 1'b0;
            end
            @(negedge clk);
            check_val($sformatf("bad%0d c%0d busy", n, c), bus.out_busy, 1'b0);
            check_val($sformatf("bad%0d c%0d done", n, c), bus.out_done, (c == 1));
            check_val($sformatf("bad%0d c%0d err", n, c), bus.out_err, (c == 0) ? (model_err != 0) : 1'b1);
            check_val($sformatf("bad%0d c%0d strobes", n, c),
                      {bus.out_w_rd_en, bus.out_d_rd_en, bus.out_sa_sel, bus.out_row_valid, bus.out_res_wr_en}, '0);
            @(posedge clk);
            #1;
        end
        model_err = 1;
        $display("job n=%0d rejected checks=%0d", n, n_checks);
    endtask

    initial begin
        bus.in_start     = 1'b0;
        bus.in_abort     = 1'b0;
        bus.in_num_vec   = '0;
        bus.in_res_valid = 1'b0;

        @(negedge clk);
        check_val("reset_outs", all_outs(), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(4);

        // Asynchronous reset in the middle of activation streaming.
        bus.in_start   = 1'b1;
        bus.in_num_vec = W_CNT'(4);
        @(posedge clk);
        #1 bus.in_start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_val("rst_pre_d_rd", {bus.out_d_rd_en, bus.out_d_rd_addr}, {1'b1, 8'd1});
        #2 rst = 1'b1;
        #1;
        check_val("rst_async_outs", all_outs(), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_after_busy", bus.out_busy, 1'b0);
        check_val("rst_after_outs", all_outs(), '0);
        @(posedge clk);
        #1;
        model_err = 0;
        $display("job n=4 reset mid-stream checks=%0d", n_checks);

        run_job(4, 15, 1'b0, -1);
        bad_job(0);
        bad_job(257);
        run_job(256, int'($urandom_range(10, 20)), 1'b0, -1);
        idle_cycles(3);
        run_job(4, 15, 1'b1, -1);
        run_job(4, 15, 1'b0, 5);
        run_job(4, 15, 1'b0, 22);
        run_job(2, 12, 1'b0, -1);
        for (int j = 0; j < 6; j++) begin
            idle_cycles(int'($urandom_range(1, 4)));
            run_job(int'($urandom_range(1, 24)), int'($urandom_range(10, 20)),
                    1'($urandom_range(1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
